// File: rtl/cmd_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cmd_scheduler
//  Description : Sensor command scheduler. Accepts one command at a time
//                into a single-entry buffer, turns one-shot commands into
//                sensor read requests, and maintains a per-channel table of
//                continuous temperature/humidity modes that a periodic scan
//                converts into requests, one channel per cycle.
//  Ports       : clk, rst_n               clock, async active-low reset
//                cmd_valid/ready/instr/addr  command input handshake
//                req_valid/ready/addr/type/cont  sensor read request output
//                err_addr                 pulse: command addressed a bad channel
//                overrun                  pulse: tick arrived mid-scan
//                cont_temp, cont_humid    continuous-mode table
//  Revision    : 1.0 - initial release
// ============================================================================
module cmd_scheduler #(
  parameter int NUM_CH = 8,
  parameter int ADDR_W = 5,
  parameter int PERIOD = 50000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_instr,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic [1:0]        req_type,
  output logic              req_cont,
  output logic              err_addr,
  output logic              overrun,
  output logic [NUM_CH-1:0] cont_temp,
  output logic [NUM_CH-1:0] cont_humid
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_EXEC  = 2'd1;
  localparam logic [1:0] c_ISSUE = 2'd2;
  localparam logic [1:0] c_SCAN  = 2'd3;

  localparam logic [1:0] c_TYPE_TEMP   = 2'b01;
  localparam logic [1:0] c_TYPE_HUMID  = 2'b10;
  localparam logic [1:0] c_TYPE_STATUS = 2'b11;

  localparam int                c_CNT_W    = $clog2(PERIOD);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(PERIOD - 1);
  localparam logic [ADDR_W:0]   c_NUM_CH   = (ADDR_W + 1)'(NUM_CH);
  localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(NUM_CH - 1);

  logic [1:0]         r_state;
  logic               r_buf_full;
  logic [2:0]         r_buf_instr;
  logic [ADDR_W-1:0]  r_buf_addr;
  logic [ADDR_W-1:0]  r_req_addr;
  logic [1:0]         r_req_type;
  logic               r_req_cont;
  logic               r_overrun;
  logic [NUM_CH-1:0]  r_cont_temp;
  logic [NUM_CH-1:0]  r_cont_humid;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_tick_pend;
  logic [ADDR_W-1:0]  r_scan_idx;
  logic               r_scan_act;

  logic [1:0]         w_state_nxt;
  logic               w_buf_clear;
  logic [ADDR_W-1:0]  w_req_addr_nxt;
  logic [1:0]         w_req_type_nxt;
  logic               w_req_cont_nxt;
  logic [NUM_CH-1:0]  w_temp_nxt;
  logic [NUM_CH-1:0]  w_humid_nxt;
  logic [ADDR_W-1:0]  w_idx_nxt;
  logic               w_act_nxt;
  logic               w_scan_start;
  logic               w_tick;
  logic               w_addr_bad;
  logic [NUM_CH-1:0]  w_buf_sel;
  logic [NUM_CH-1:0]  w_idx_sel;
  logic               w_idx_hit;
  logic               w_idx_temp;

  // One-hot decodes of the buffered address and the scan index; these avoid
  // indexing the NUM_CH-wide table with a wider address.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_sel
    assign w_buf_sel[g] = (r_buf_addr == ADDR_W'(g));
    assign w_idx_sel[g] = (r_scan_idx == ADDR_W'(g));
  end

  assign w_tick     = (r_cnt == c_CNT_LAST);
  assign w_addr_bad = ({1'b0, r_buf_addr} >= c_NUM_CH);
  assign w_idx_temp = |(r_cont_temp & w_idx_sel);
  assign w_idx_hit  = |((r_cont_temp | r_cont_humid) & w_idx_sel);

  assign cmd_ready  = ~r_buf_full;
  assign req_valid  = (r_state == c_ISSUE);
  assign req_addr   = r_req_addr;
  assign req_type   = r_req_type;
  assign req_cont   = r_req_cont;
  assign err_addr   = (r_state == c_EXEC) && w_addr_bad;
  assign overrun    = r_overrun;
  assign cont_temp  = r_cont_temp;
  assign cont_humid = r_cont_humid;

  always_comb begin
    w_state_nxt    = r_state;
    w_buf_clear    = 1'b0;
    w_req_addr_nxt = r_req_addr;
    w_req_type_nxt = r_req_type;
    w_req_cont_nxt = r_req_cont;
    w_temp_nxt     = r_cont_temp;
    w_humid_nxt    = r_cont_humid;
    w_idx_nxt      = r_scan_idx;
    w_act_nxt      = r_scan_act;
    w_scan_start   = 1'b0;

    case (r_state)
      c_IDLE: begin
        if (r_buf_full) begin
          w_state_nxt = c_EXEC;
        end else if (r_tick_pend && |(r_cont_temp | r_cont_humid)) begin
          w_state_nxt  = c_SCAN;
          w_idx_nxt    = '0;
          w_act_nxt    = 1'b1;
          w_scan_start = 1'b1;
        end
      end

      c_EXEC: begin
        w_buf_clear = 1'b1;
        if (!w_addr_bad) begin
          case (r_buf_instr)
            3'd3: begin
              w_temp_nxt  = r_cont_temp | w_buf_sel;
              w_humid_nxt = r_cont_humid & ~w_buf_sel;
            end
            3'd4: begin
              w_humid_nxt = r_cont_humid | w_buf_sel;
              w_temp_nxt  = r_cont_temp & ~w_buf_sel;
            end
            3'd5:    w_temp_nxt  = r_cont_temp & ~w_buf_sel;
            3'd6:    w_humid_nxt = r_cont_humid & ~w_buf_sel;
            default: ;
          endcase
        end
        if (!w_addr_bad && (r_buf_instr <= 3'd4)) begin
          w_state_nxt    = c_ISSUE;
          w_req_addr_nxt = r_buf_addr;
          w_req_cont_nxt = 1'b0;
          case (r_buf_instr)
            3'd0:       w_req_type_nxt = c_TYPE_STATUS;
            3'd1, 3'd3: w_req_type_nxt = c_TYPE_TEMP;
            default:    w_req_type_nxt = c_TYPE_HUMID;
          endcase
        end else begin
          // Resume an interrupted scan at the retained index.
          w_state_nxt = r_scan_act ? c_SCAN : c_IDLE;
        end
      end

      c_ISSUE: begin
        if (req_ready) begin
          if (r_req_cont) begin
            // Scan-generated request done: move past this channel.
            if (r_scan_idx == c_LAST_IDX) begin
              w_state_nxt = c_IDLE;
              w_idx_nxt   = '0;
              w_act_nxt   = 1'b0;
            end else begin
              w_state_nxt = c_SCAN;
              w_idx_nxt   = r_scan_idx + ADDR_W'(1);
            end
          end else begin
            w_state_nxt = r_scan_act ? c_SCAN : c_IDLE;
          end
        end
      end

      c_SCAN: begin
        if (r_buf_full) begin
          // Commands preempt the scan between channels; index is kept.
          w_state_nxt = c_EXEC;
        end else if (w_idx_hit) begin
          w_state_nxt    = c_ISSUE;
          w_req_addr_nxt = r_scan_idx;
          w_req_type_nxt = w_idx_temp ? c_TYPE_TEMP : c_TYPE_HUMID;
          w_req_cont_nxt = 1'b1;
        end else if (r_scan_idx == c_LAST_IDX) begin
          w_state_nxt = c_IDLE;
          w_idx_nxt   = '0;
          w_act_nxt   = 1'b0;
        end else begin
          w_idx_nxt = r_scan_idx + ADDR_W'(1);
        end
      end

      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_IDLE;
      r_buf_full   <= 1'b0;
      r_buf_instr  <= 3'd0;
      r_buf_addr   <= '0;
      r_req_addr   <= '0;
      r_req_type   <= 2'b00;
      r_req_cont   <= 1'b0;
      r_overrun    <= 1'b0;
      r_cont_temp  <= '0;
      r_cont_humid <= '0;
      r_cnt        <= '0;
      r_tick_pend  <= 1'b0;
      r_scan_idx   <= '0;
      r_scan_act   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_req_addr   <= w_req_addr_nxt;
      r_req_type   <= w_req_type_nxt;
      r_req_cont   <= w_req_cont_nxt;
      r_cont_temp  <= w_temp_nxt;
      r_cont_humid <= w_humid_nxt;
      r_scan_idx   <= w_idx_nxt;
      r_scan_act   <= w_act_nxt;

      if (w_buf_clear) begin
        r_buf_full <= 1'b0;
      end else if (cmd_valid && !r_buf_full) begin
        r_buf_full  <= 1'b1;
        r_buf_instr <= cmd_instr;
        r_buf_addr  <= cmd_addr;
      end

      r_cnt <= w_tick ? '0 : r_cnt + c_CNT_W'(1);

      // A tick outranks the scan-start clear so it is never lost; repeated
      // ticks simply re-set the same flag.
      if (w_tick)
        r_tick_pend <= 1'b1;
      else if (w_scan_start)
        r_tick_pend <= 1'b0;

      r_overrun <= w_tick && r_scan_act;
    end
  end

endmodule
`default_nettype wire

// File: doc/cmd_scheduler.md
CMD_SCHEDULER -- requirements
Module: cmd_scheduler

Interface
REQ-001 Parameter: NUM_CH, 8, number of sensor channels (2..32).
REQ-002 Parameter: ADDR_W, 5, channel address width; NUM_CH SHALL be at most 2**ADDR_W.
REQ-003 Parameter: PERIOD, 50000000, clock cycles between continuous-sampling ticks (>= 2*NUM_CH+4).
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 CLK  in  1  system clock; all state rising-edge.
REQ-006 RST_N  in  1  asynchronous active-low reset.
REQ-007 CMD_VALID  in  1  command present.
REQ-008 CMD_READY  out  1  command buffer empty; transfer on CMD_VALID&CMD_READY at a rising edge.
REQ-009 CMD_INSTR  in  3  0 status, 1 temp, 2 humid, 3 temp-cont, 4 humid-cont, 5 stop-temp-cont, 6 stop-humid-cont, 7 idle.
REQ-010 CMD_ADDR  in  ADDR_W  target channel.
REQ-011 REQ_VALID  out  1  sensor read request pending.
REQ-012 REQ_READY  in  1  reader accepts; transfer on REQ_VALID&REQ_READY.
REQ-013 REQ_ADDR  out  ADDR_W  requested channel.
REQ-014 REQ_TYPE  out  2  01 temperature, 10 humidity, 11 status.
REQ-015 REQ_CONT  out  1  1 = request generated by continuous scan.
REQ-016 ERR_ADDR  out  1  one-cycle pulse: command with CMD_ADDR >= NUM_CH.
REQ-017 OVERRUN  out  1  one-cycle pulse: tick arrived while a scan was still in progress.
REQ-018 CONT_TEMP  out  NUM_CH  per-channel continuous-temperature flag.
REQ-019 CONT_HUMID  out  NUM_CH  per-channel continuous-humidity flag.

Function
REQ-020 One-entry command buffer; CMD_READY SHALL be 1 exactly when the buffer is empty; buffer empties at the EXEC state.
REQ-021 FSM states: IDLE, EXEC, ISSUE, SCAN.
REQ-022 IDLE: buffer full -> EXEC; else tick pending and any channel flag set -> SCAN with index 0; else stay.
REQ-023 EXEC (one cycle): decode, update mode table, pulse ERR_ADDR if applicable; -> ISSUE if request needed, else return to IDLE (or SCAN if a scan was interrupted).
REQ-024 REQ_VALID SHALL be 1 only in ISSUE; REQ_ADDR/REQ_TYPE/REQ_CONT held stable until REQ_READY; ISSUE exits on the handshake edge.
REQ-025 Command accepted at edge k SHALL yield REQ_VALID=1 from edge k+2 (IDLE, no scan in progress).
REQ-026 Instr 0/1/2: one request, type 11/01/10, REQ_CONT=0; table unchanged.
REQ-027 Instr 3: CONT_TEMP[a]=1, CONT_HUMID[a]=0, plus immediate request type 01, REQ_CONT=0; instr 4 symmetric for humidity (type 10).
REQ-028 Instr 5: CONT_TEMP[a]=0, no request; instr 6: CONT_HUMID[a]=0, no request; stop on an inactive mode is a no-op.
REQ-029 Instr 7: consumed, no effect, no request.
REQ-030 CMD_ADDR >= NUM_CH: consumed, ERR_ADDR pulse in EXEC, no table change, no request.
REQ-031 Tick counter free-runs 0..PERIOD-1, wrapping to 0; tick event at count PERIOD-1 sets a tick-pending flag.
REQ-032 SCAN examines one channel per cycle in ascending order: active flag -> ISSUE with type 01 (temp) or 10 (humid), REQ_CONT=1, then resume at index+1; after index NUM_CH-1 -> IDLE, tick-pending cleared at scan start.
REQ-033 Buffered command SHALL preempt SCAN between channels (never mid-ISSUE); scan index retained and resumed after the command completes.
REQ-034 Tick during an active scan: tick-pending set again, OVERRUN pulsed; multiple ticks coalesce into one pending scan.
REQ-035 Table updates from EXEC take effect for the channel examined in the same or later SCAN cycle.

Reset
REQ-036 RST_N low SHALL immediately force: state IDLE, buffer empty (CMD_READY=1 after release), REQ_VALID=0, REQ_ADDR=0, REQ_TYPE=00, REQ_CONT=0, ERR_ADDR=0, OVERRUN=0, CONT_TEMP=0, CONT_HUMID=0, counter=0, tick-pending=0, scan index=0.
REQ-037 Reset during ISSUE SHALL drop REQ_VALID without handshake; no request replayed after release.

Verification
REQ-038 Instr 1 addr 3, REQ_READY=1 -> REQ_VALID at accept+2, REQ_ADDR=3, REQ_TYPE=01, REQ_CONT=0, one cycle.
REQ-039 Instr 3 addr 2, PERIOD=40 -> immediate request (01, CONT=0), then one request (addr 2, 01, CONT=1) per 40 cycles; instr 5 addr 2 -> requests stop, CONT_TEMP=0.
REQ-040 Instr 2 addr 9 with NUM_CH=8 -> ERR_ADDR single pulse, no REQ_VALID, table unchanged.
REQ-041 Channels 1,5 continuous, REQ_READY held 0 for 60 cycles at PERIOD=40 -> REQ_VALID stable with addr 1, OVERRUN pulse, single follow-up scan.
REQ-042 Instr 0 addr 4 arriving mid-scan -> status request (11, CONT=0) issued before resumed scan request for channel 5.
REQ-043 RST_N low while REQ_VALID=1 -> all outputs at reset values in same cycle; no request after release.
